// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer.
//   NUM_CH - number of mux channels scanned per snapshot
//   SEL_W  - width of the mux select
//   CNT_W  - width of the settle counter (SETTLE_CYCLES up to 255)
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/scan_settle_timer.sv
// Settle-time counter for one mux channel.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   clr_i - hold the counter at zero (asserted outside SETTLE)
//   tc_o  - terminal count: this is the last settle cycle of the channel
// The counter wraps to zero on terminal count so the next channel starts fresh.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Polls an external 4:1 mux: steps select through channels 0..3, samples the
// mux output in the last settle cycle of each channel, and presents the four
// bits as one snapshot over a valid/ready handshake.
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, discards any partial scan
//   start      - scan request, honoured only when idle
//   select     - registered mux select
//   y_in       - mux output
//   scan_data  - snapshot, bit k sampled while select==k
//   scan_valid - snapshot available
//   scan_ready - consumer accepts snapshot
//   busy       - scan in progress or snapshot pending
//   overrun    - sticky, start seen while busy
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          AUTO_RESTART  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [SEL_W-1:0] select,
  input  logic             y_in,
  output logic [NUM_CH-1:0] scan_data,
  output logic             scan_valid,
  input  logic             scan_ready,
  output logic             busy,
  output logic             overrun
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-2:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               tc;

  scan_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q != SETTLE),
    .tc_o (tc)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q | (start && (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          ch_d    = '0;
        end
      end
      SETTLE: begin
        if (tc) begin
          if (ch_q == SEL_W'(NUM_CH - 1)) begin
            // Last channel goes straight into the snapshot, not via the shadow.
            data_d  = {y_in, shadow_q};
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            shadow_d[ch_q] = y_in;
            ch_d           = ch_q + SEL_W'(1);
          end
        end
      end
      DONE: begin
        if (valid_q && scan_ready) begin
          valid_d = 1'b0;
          ch_d    = '0;
          state_d = AUTO_RESTART ? SETTLE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Select is registered from the next-state view so it changes on the same
    // edge as the channel counter.
    sel_d = (state_d == SETTLE) ? ch_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign select     = sel_q;
  assign scan_data  = data_q;
  assign scan_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Sequencer that sits directly upstream of the 4:1 mux. It drives the mux's 2-bit select through channels 0..3 and samples the mux's 1-bit output after a programmable settle time. It then assembles the four samples into a 4-bit snapshot and hands that snapshot to a consumer over a valid/ready handshake. It turns the combinational mux into a polled 4-channel bit-capture path.

Parameters:
SETTLE_CYCLES, 1, cycles each select value is held before sampling; legal range 1..255
AUTO_RESTART, 0, 1 = start a new scan automatically after each snapshot handshake

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle scan request; honoured only in IDLE
select  out  2  registered select to the mux select input
y_in  in  1  mux output (y_out of the 4:1 mux)
scan_data  out  4  snapshot; bit k = y_in sampled while select==k
scan_valid  out  1  snapshot available
scan_ready  in  1  consumer accepts snapshot
busy  out  1  1 whenever state != IDLE
overrun  out  1  sticky; set when start is seen while busy

Behaviour:
- Reset values (applied at any rst edge, including mid-scan):
  - state=IDLE, select=0, scan_data=0, scan_valid=0, busy=0, overrun=0.
  - Channel counter=0, settle counter=0, shadow register=0.
  - Any partial scan is discarded.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - select=0, busy=0.
  - start=1 → SETTLE with ch=0, cnt=0.
- SETTLE:
  - select=ch, busy=1.
  - cnt increments each cycle.
  - On the cycle with cnt==SETTLE_CYCLES-1: shadow[ch] <= y_in, cnt <= 0.
    - If ch==3: scan_data <= {y_in, shadow[2:0]}, scan_valid <= 1, → DONE.
    - Else: ch <= ch+1 (select updates next cycle).
- DONE:
  - select=0, scan_valid=1, busy=1.
  - scan_data and scan_valid are held stable while scan_ready=0.
  - On scan_valid & scan_ready: scan_valid <= 0.
    - AUTO_RESTART=0 → IDLE.
    - AUTO_RESTART=1 → SETTLE with ch=0, cnt=0.
- Latency: start sampled at edge E0.
  - select=k is driven for cycles 1+k*S .. (k+1)*S, where S=SETTLE_CYCLES.
  - scan_valid rises in cycle 1+4*S (S=1 → cycle 5).
- Sampling: y_in is taken only in the last settle cycle of each channel. Earlier glitches and changes are ignored.
- start while busy (SETTLE or DONE, including the handshake cycle): ignored, and overrun <= 1. Only rst clears overrun.
- scan_ready while scan_valid=0: no effect.
- rst has priority over start and over the handshake in the same cycle.
- Counter widths: cnt is 8 bits, ch is 2 bits. No wrap beyond 3; the ch==3 terminal condition exits SETTLE.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SETTLE, DONE}
  - localparams NUM_CH=4, SEL_W=2, CNT_W=8
- One natural sub-module: scan_settle_timer (cnt register with clear/terminal-count output), instantiated once.
- The 4:1 mux itself is not part of this block; it is connected externally.

Test Plan:
1. S=1, mux inputs i=4'b1010 static, start pulse cycle 0, scan_ready=1 → select 0,1,2,3 in cycles 1–4; scan_valid=1 cycle 5 with scan_data=4'b1010; busy=0 cycle 6.
2. Backpressure, S=1, i=4'b0011: scan_ready=0 cycles 5–7, =1 cycle 8 → scan_data=4'b0011 and scan_valid=1 stable cycles 5–8; start pulse in cycle 6 ignored and overrun=1 from cycle 7 onward.
3. S=3, i=4'b1100 → each select value held 3 cycles; scan_valid rises in cycle 13; scan_data=4'b1100.
4. S=2, i[1] toggles 0→1 in first settle cycle of channel 1 → scan_data[1]=1; toggle 1→0 in the last settle cycle before the sample edge → scan_data[1]=0.
5. Reset mid-scan: rst=1 in cycle 3 of an S=1 scan → cycle 4 select=0, busy=0, scan_valid=0, overrun=0; no snapshot ever appears.
6. AUTO_RESTART=1, S=1: first scan i=4'b1010 handshake in cycle 5 → select=0 in cycle 6; i changed to 4'b0110 before cycle 6 → second snapshot 4'b0110 valid in cycle 10.
